// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Gives a same-cycle prediction to fetch and trains from execute, issuing a registered redirect on a mispredict.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fetch_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              res_valid_i,
    input  logic              res_jump_i,
    input  logic [ADDR_W-1:0] res_pc_i,
    input  logic              res_taken_i,
    input  logic [ADDR_W-1:0] res_target_i,
    input  logic              res_pred_taken_i,
    input  logic [ADDR_W-1:0] res_pred_target_i,
    input  logic              flush_i,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic [31:0]       mispredict_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int unsigned CNT_WT_I = 2 ** (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_WT_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - 1'b1;
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];

    // Lookup: reads the table as it stands, so same-cycle updates are not visible.
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;

    assign f_idx         = fetch_pc_i[IDX_W+1:2];
    assign f_tag         = fetch_pc_i[ADDR_W-1:IDX_W+2];
    assign pred_hit_o    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken_o  = pred_hit_o && cnt_q[f_idx][CNT_W-1];
    assign pred_target_o = pred_taken_o ? target_q[f_idx] : (fetch_pc_i + PC_INC);

    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_tag;
    logic              r_hit;
    logic              actual_taken;
    logic              mispredict;
    logic [ADDR_W-1:0] correct_pc;
    logic              upd_en;
    logic [ADDR_W-1:0] upd_target;
    logic [CNT_W-1:0]  upd_cnt;

    assign r_idx        = res_pc_i[IDX_W+1:2];
    assign r_tag        = res_pc_i[ADDR_W-1:IDX_W+2];
    assign r_hit        = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign actual_taken = res_jump_i | res_taken_i;
    assign mispredict   = res_valid_i && ((actual_taken != res_pred_taken_i) ||
                          (actual_taken && (res_target_i != res_pred_target_i)));
    assign correct_pc   = actual_taken ? res_target_i : (res_pc_i + PC_INC);

    always_comb begin
        upd_en     = 1'b0;
        upd_target = target_q[r_idx];
        upd_cnt    = cnt_q[r_idx];
        if (res_valid_i) begin
            if (r_hit) begin
                upd_en = 1'b1;
                if (res_jump_i) begin
                    upd_cnt    = CNT_MAX;
                    upd_target = res_target_i;
                end else if (res_taken_i) begin
                    upd_cnt    = (cnt_q[r_idx] == CNT_MAX) ? cnt_q[r_idx] : cnt_q[r_idx] + 1'b1;
                    upd_target = res_target_i;
                end else begin
                    upd_cnt    = (cnt_q[r_idx] == '0) ? cnt_q[r_idx] : cnt_q[r_idx] - 1'b1;
                end
            end else if (actual_taken) begin
                upd_en     = 1'b1;
                upd_target = res_target_i;
                upd_cnt    = res_jump_i ? CNT_MAX : CNT_WT;
            end
        end
    end

    // Flush invalidates every entry and drops the update, but leaves counters alone.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic we;
        assign we = upd_en && (r_idx == IDX_W'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q[gi]  <= 1'b0;
                tag_q[gi]    <= '0;
                target_q[gi] <= '0;
                cnt_q[gi]    <= CNT_WNT;
            end else if (flush_i) begin
                valid_q[gi]  <= 1'b0;
            end else if (we) begin
                valid_q[gi]  <= 1'b1;
                tag_q[gi]    <= r_tag;
                target_q[gi] <= upd_target;
                cnt_q[gi]    <= upd_cnt;
            end
        end
    end

    logic              redirect_valid_q;
    logic [ADDR_W-1:0] redirect_addr_q;
    logic [ADDR_W-1:0] redirect_addr_d;
    logic [31:0]       mispredict_cnt_q;
    logic [31:0]       mispredict_cnt_d;

    assign redirect_addr_d  = mispredict ? correct_pc : redirect_addr_q;
    assign mispredict_cnt_d = mispredict ? mispredict_cnt_q + 32'd1 : mispredict_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_addr_q  <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            redirect_valid_q <= mispredict;
            redirect_addr_q  <= redirect_addr_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_addr_o  = redirect_addr_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: expected redirects are queued as resolutions are driven
// and compared one cycle later; predictions are compared against fixed expectations.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_pc = 32'h0;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        res_valid = 1'b0, res_jump = 1'b0, res_taken = 1'b0, res_pred_taken = 1'b0;
    logic [31:0] res_pc = 32'h0, res_target = 32'h0, res_pred_target = 32'h0;
    logic        flush = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_addr, mispredict_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] a;
    } exp_t;
    exp_t sb[$];
    logic [31:0] model_cnt  = 32'd0;
    logic [31:0] model_last = 32'd0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16), .CNT_W(2), .ADDR_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_pc_i        (fetch_pc),
        .pred_hit_o        (pred_hit),
        .pred_taken_o      (pred_taken),
        .pred_target_o     (pred_target),
        .res_valid_i       (res_valid),
        .res_jump_i        (res_jump),
        .res_pc_i          (res_pc),
        .res_taken_i       (res_taken),
        .res_target_i      (res_target),
        .res_pred_taken_i  (res_pred_taken),
        .res_pred_target_i (res_pred_target),
        .flush_i           (flush),
        .redirect_valid_o  (redirect_valid),
        .redirect_addr_o   (redirect_addr),
        .mispredict_cnt_o  (mispredict_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pred(input logic [31:0] pc, input logic hit, input logic tk,
                              input logic [31:0] tgt);
        fetch_pc = pc;
        #1;
        $display("lookup pc=%h hit=%0b taken=%0b target=%h", pc, pred_hit, pred_taken, pred_target);
        check("pred_hit", 32'(pred_hit), 32'(hit));
        check("pred_taken", 32'(pred_taken), 32'(tk));
        check("pred_target", pred_target, tgt);
    endtask

    task automatic drive_res(input logic jump, input logic [31:0] pc, input logic tk,
                             input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                             input logic fl);
        logic at, mp;
        exp_t e;
        res_valid = 1'b1; res_jump = jump; res_pc = pc; res_taken = tk;
        res_target = tgt; res_pred_taken = pt; res_pred_target = ptgt; flush = fl;
        at = jump | tk;
        mp = (at != pt) || (at && (tgt != ptgt));
        e.v = mp;
        e.a = mp ? (at ? tgt : pc + 32'd4) : model_last;
        if (mp) begin
            model_cnt  = model_cnt + 32'd1;
            model_last = e.a;
        end
        sb.push_back(e);
        $display("resolve pc=%h jump=%0b taken=%0b target=%h pred=%0b/%h flush=%0b -> redirect=%0b addr=%h",
                 pc, jump, tk, tgt, pt, ptgt, fl, e.v, e.a);
    endtask

    task automatic drive_idle();
        exp_t e;
        res_valid = 1'b0; flush = 1'b0;
        e.v = 1'b0;
        e.a = model_last;
        sb.push_back(e);
    endtask

    task automatic finish_cycle();
        exp_t e;
        @(posedge clk);
        #1;
        res_valid = 1'b0; flush = 1'b0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("redirect_valid", 32'(redirect_valid), 32'(e.v));
            check("redirect_addr", redirect_addr, e.a);
        end
        check("mispredict_cnt", mispredict_cnt, model_cnt);
    endtask

    task automatic res_cycle(input logic jump, input logic [31:0] pc, input logic tk,
                             input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                             input logic fl);
        drive_res(jump, pc, tk, tgt, pt, ptgt, fl);
        finish_cycle();
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Reset state
        check_pred(32'h100, 1'b0, 1'b0, 32'h104);
        check("reset_redirect_valid", 32'(redirect_valid), 32'd0);
        check("reset_redirect_addr", redirect_addr, 32'd0);
        check("reset_mispredict_cnt", mispredict_cnt, 32'd0);

        // First taken branch allocates weakly taken
        res_cycle(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        check_pred(32'h100, 1'b1, 1'b1, 32'h200);

        // Saturate up, then two not-takens bring it to weakly not-taken
        repeat (3) res_cycle(1'b0, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
        res_cycle(1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
        check_pred(32'h100, 1'b1, 1'b1, 32'h200);
        res_cycle(1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
        check_pred(32'h100, 1'b1, 1'b0, 32'h104);

        // Aliasing: JAL at 0x140 replaces the 0x100 entry
        res_cycle(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        res_cycle(1'b1, 32'h140, 1'b0, 32'h300, 1'b0, 32'h0, 1'b0);
        check_pred(32'h100, 1'b0, 1'b0, 32'h104);
        check_pred(32'h140, 1'b1, 1'b1, 32'h300);

        // Correct prediction, then wrong target
        res_cycle(1'b1, 32'h140, 1'b0, 32'h300, 1'b1, 32'h300, 1'b0);
        drive_idle();
        finish_cycle();
        res_cycle(1'b1, 32'h140, 1'b0, 32'h304, 1'b1, 32'h300, 1'b0);
        check_pred(32'h140, 1'b1, 1'b1, 32'h304);

        // Not-taken miss leaves the aliased entry alone
        res_cycle(1'b0, 32'h180, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_pred(32'h140, 1'b1, 1'b1, 32'h304);

        // pc+4 wraps at the top of the address space
        res_cycle(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1234, 1'b0);

        // Back-to-back mispredicts each carry their own address
        res_cycle(1'b0, 32'h204, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
        res_cycle(1'b0, 32'h208, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
        drive_idle();
        finish_cycle();
        check_pred(32'h204, 1'b1, 1'b1, 32'h400);

        // Flush wins over the update but the redirect still happens
        res_cycle(1'b0, 32'h30C, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1);
        check_pred(32'h204, 1'b0, 1'b0, 32'h208);
        check_pred(32'h30C, 1'b0, 1'b0, 32'h310);
        check_pred(32'h140, 1'b0, 1'b0, 32'h144);

        // Same-cycle lookup sees the table before the update
        drive_res(1'b0, 32'h700, 1'b1, 32'h800, 1'b0, 32'h0, 1'b0);
        check_pred(32'h700, 1'b0, 1'b0, 32'h704);
        finish_cycle();
        check_pred(32'h700, 1'b1, 1'b1, 32'h800);

        // Reset with a redirect in flight clears it immediately
        res_cycle(1'b0, 32'h710, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_redirect_valid", 32'(redirect_valid), 32'd0);
        check("midreset_redirect_addr", redirect_addr, 32'd0);
        check("midreset_mispredict_cnt", mispredict_cnt, 32'd0);
        sb.delete();
        model_cnt  = 32'd0;
        model_last = 32'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_idle();
        finish_cycle();
        check_pred(32'h700, 1'b0, 1'b0, 32'h704);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
